// File: rtl/wddl_word_collect_32.sv
// wddl_word_collect_32: phase sequencer and dual-rail capture buffer for a WDDL
// 32-bit XOR tree. It drives precharge/evaluate upstream, captures WORDS evaluated
// words into a dual-rail buffer and offers the block downstream with valid/ready.
// Optional build macro: WDDL_PRECHARGE_CHECK_EN adds a failed-precharge check in
// the last PRE cycle of every word.
module wddl_word_collect_32 #(
    parameter int unsigned PRE_CYC  = 1,
    parameter int unsigned EVAL_CYC = 2,
    parameter int unsigned WORDS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_in,
    output logic                pre_out,
    output logic [1:0]          word_idx,
    input  logic [31:0]         d_p_in,
    input  logic [31:0]         d_n_in,
    output logic [32*WORDS-1:0] q_p_out,
    output logic [32*WORDS-1:0] q_n_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                busy_out,
    output logic                err_out
);

    localparam int unsigned W      = 32 * WORDS;
    localparam int unsigned WC_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PC_MAX = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
    localparam int unsigned PC_W   = (PC_MAX > 1) ? $clog2(PC_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_EVAL = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [WC_W-1:0] wc_q;
    logic [W-1:0]    q_p_q;
    logic [W-1:0]    q_n_q;
    logic            pre_q;
    logic            valid_q;
    logic            busy_q;
    logic            err_q;

    logic pre_last_c;
    logic eval_last_c;
    logic word_last_c;
    logic rail_err_c;
    logic pre_err_c;

    // Phase-end decodes and rail checks on the upstream word.
    always_comb begin
        pre_last_c  = (pc_q == PC_W'(PRE_CYC - 1));
        eval_last_c = (pc_q == PC_W'(EVAL_CYC - 1));
        word_last_c = (wc_q == WC_W'(WORDS - 1));
        // A valid dual-rail bit always has p != n; p == n is either 0/0 or 1/1.
        rail_err_c  = |(~(d_p_in ^ d_n_in));
`ifdef WDDL_PRECHARGE_CHECK_EN
        // Upstream must still sit at 0/0 at the end of precharge.
        pre_err_c   = |(d_p_in | d_n_in);
`else
        pre_err_c   = 1'b0;
`endif
    end

    // Sequencer FSM with registered outputs and word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            wc_q    <= '0;
            q_p_q   <= '0;
            q_n_q   <= '0;
            pre_q   <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        q_p_q   <= '0;
                        q_n_q   <= '0;
                        err_q   <= 1'b0;
                        wc_q    <= '0;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        pre_q   <= 1'b1;
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (pre_last_c) begin
                        if (pre_err_c) begin
                            err_q <= 1'b1;
                        end
                        pc_q    <= '0;
                        pre_q   <= 1'b0;
                        state_q <= S_EVAL;
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                S_EVAL: begin
                    if (eval_last_c) begin
                        for (int unsigned k = 0; k < WORDS; k++) begin
                            if (wc_q == WC_W'(k)) begin
                                q_p_q[32*k +: 32] <= d_p_in;
                                q_n_q[32*k +: 32] <= d_n_in;
                            end
                        end
                        if (rail_err_c) begin
                            err_q <= 1'b1;
                        end
                        pc_q  <= '0;
                        pre_q <= 1'b1;
                        if (word_last_c) begin
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else begin
                            wc_q    <= wc_q + WC_W'(1);
                            state_q <= S_PRE;
                        end
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                S_HOLD: begin
                    // Buffer is retained after hand-off; only a new start clears it.
                    if (ready_in) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Word index is the word counter, zero-extended or truncated to 2 bits.
    generate
        if (WC_W >= 2) begin : g_idx_trunc
            assign word_idx = wc_q[1:0];
        end else begin : g_idx_ext
            assign word_idx = {1'b0, wc_q};
        end
    endgenerate

    assign pre_out   = pre_q;
    assign q_p_out   = q_p_q;
    assign q_n_out   = q_n_q;
    assign valid_out = valid_q;
    assign busy_out  = busy_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_wddl_word_collect_32.sv
// Bench for wddl_word_collect_32: two instances (default timing and PRE=2/EVAL=3)
// share one input stream; each is compared every cycle against a block-offset
// model, with hand-computed literal checks for the nominal, error and timing cases.
module tb_wddl_word_collect_32;

    localparam int NW = 4;
    localparam int W  = 32 * NW;
    localparam int P0 = 1;
    localparam int E0 = 2;
    localparam int P1 = 2;
    localparam int E1 = 3;
`ifdef WDDL_PRECHARGE_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start_in;
    logic         ready_in;
    logic [31:0]  d_p_in;
    logic [31:0]  d_n_in;
    logic [1:0]   pre_o;
    logic [1:0]   idx_o [2];
    logic [W-1:0] qp_o [2];
    logic [W-1:0] qn_o [2];
    logic [1:0]   valid_o;
    logic [1:0]   busy_o;
    logic [1:0]   err_o;

    wddl_word_collect_32 #(.PRE_CYC(P0), .EVAL_CYC(E0), .WORDS(NW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .pre_out(pre_o[0]),
        .word_idx(idx_o[0]), .d_p_in(d_p_in), .d_n_in(d_n_in),
        .q_p_out(qp_o[0]), .q_n_out(qn_o[0]), .valid_out(valid_o[0]),
        .ready_in(ready_in), .busy_out(busy_o[0]), .err_out(err_o[0])
    );

    wddl_word_collect_32 #(.PRE_CYC(P1), .EVAL_CYC(E1), .WORDS(NW)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .pre_out(pre_o[1]),
        .word_idx(idx_o[1]), .d_p_in(d_p_in), .d_n_in(d_n_in),
        .q_p_out(qp_o[1]), .q_n_out(qn_o[1]), .valid_out(valid_o[1]),
        .ready_in(ready_in), .busy_out(busy_o[1]), .err_out(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 collecting (offset = cycles since start), 2 holding.
    int          m_mode [2];
    int          m_off  [2];
    int          m_idx  [2];
    logic        m_err  [2];
    logic [31:0] m_bp   [2][NW];
    logic [31:0] m_bn   [2][NW];

    int n_cmp;
    int n_bad;

    logic        s_v;
    logic        r_v;
    logic [31:0] p_v;
    logic [31:0] n_v;
    logic [31:0] words [NW];
    logic [W-1:0] nom_q;
    int          rsel;

    function automatic int pre_len(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    function automatic int blk_len(input int i);
        return (i == 0) ? (P0 + E0) : (P1 + E1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_off[i]  = 0;
            m_idx[i]  = 0;
            m_err[i]  = 1'b0;
            for (int w = 0; w < NW; w++) begin
                m_bp[i][w] = '0;
                m_bn[i][w] = '0;
            end
        end
    endtask

    // Advance instance i by one clock edge with the given inputs.
    task automatic model_step(input int i, input logic s, input logic r,
                              input logic [31:0] p, input logic [31:0] n);
        int len;
        int ph;
        int w;
        len = blk_len(i);
        case (m_mode[i])
            0: begin
                if (s) begin
                    for (int k = 0; k < NW; k++) begin
                        m_bp[i][k] = '0;
                        m_bn[i][k] = '0;
                    end
                    m_err[i]  = 1'b0;
                    m_off[i]  = 0;
                    m_idx[i]  = 0;
                    m_mode[i] = 1;
                end
            end
            1: begin
                ph = m_off[i] % len;
                w  = m_off[i] / len;
                if (PCHK && (ph == pre_len(i) - 1) && (|(p | n))) m_err[i] = 1'b1;
                if (ph == len - 1) begin
                    m_bp[i][w] = p;
                    m_bn[i][w] = n;
                    if (|(~(p ^ n))) m_err[i] = 1'b1;
                end
                m_off[i] = m_off[i] + 1;
                m_idx[i] = (m_off[i] / len > NW - 1) ? NW - 1 : m_off[i] / len;
                if (m_off[i] == NW * len) m_mode[i] = 2;
            end
            default: begin
                if (r) m_mode[i] = 0;
            end
        endcase
    endtask

    function automatic logic [W-1:0] exp_q(input int i, input bit neg);
        logic [W-1:0] v;
        for (int w = 0; w < NW; w++) v[32*w +: 32] = neg ? m_bn[i][w] : m_bp[i][w];
        return v;
    endfunction

    task automatic chk(input string name, input int i, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, i, got, exp);
        end
    endtask

    task automatic check_all();
        logic e_pre;
        for (int i = 0; i < 2; i++) begin
            e_pre = (m_mode[i] == 1) ? ((m_off[i] % blk_len(i)) < pre_len(i)) : 1'b1;
            chk("pre_out",   i, W'(pre_o[i]),   W'(e_pre));
            chk("word_idx",  i, W'(idx_o[i]),   W'(m_idx[i]));
            chk("valid_out", i, W'(valid_o[i]), W'(m_mode[i] == 2));
            chk("busy_out",  i, W'(busy_o[i]),  W'(m_mode[i] != 0));
            chk("err_out",   i, W'(err_o[i]),   W'(m_err[i]));
            chk("q_p_out",   i, qp_o[i],        exp_q(i, 1'b0));
            chk("q_n_out",   i, qn_o[i],        exp_q(i, 1'b1));
        end
    endtask

    // Inputs are applied at a falling edge, the model steps for the coming rising
    // edge, and outputs are checked at the next falling edge.
    task automatic tick(input logic s, input logic r, input logic [31:0] p,
                        input logic [31:0] n);
        start_in = s;
        ready_in = r;
        d_p_in   = p;
        d_n_in   = n;
        for (int i = 0; i < 2; i++) model_step(i, s, r, p, n);
        @(negedge clk);
        check_all();
    endtask

    task automatic lit_reset(input int i);
        chk("rst_pre",   i, W'(pre_o[i]),   W'(1));
        chk("rst_idx",   i, W'(idx_o[i]),   W'(0));
        chk("rst_valid", i, W'(valid_o[i]), W'(0));
        chk("rst_busy",  i, W'(busy_o[i]),  W'(0));
        chk("rst_err",   i, W'(err_o[i]),   W'(0));
        chk("rst_qp",    i, qp_o[i],        '0);
        chk("rst_qn",    i, qn_o[i],        '0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start_in = 1'b0;
        ready_in = 1'b0;
        d_p_in   = '0;
        d_n_in   = '0;
        model_reset();
        #1;
        lit_reset(0);
        lit_reset(1);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_mode[0] != 0 || m_mode[1] != 0) && k < 100) begin
            tick(1'b0, 1'b1, '0, '0);
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got busy after %0d cycles expected idle", k);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start_in = 1'b0;
        ready_in = 1'b0;
        d_p_in   = '0;
        d_n_in   = '0;
        model_reset();
        words[0] = 32'h00000001;
        words[1] = 32'hDEADBEEF;
        words[2] = 32'hFFFFFFFF;
        words[3] = 32'h12345678;
        nom_q    = 128'h12345678_FFFFFFFF_DEADBEEF_00000001;

        @(negedge clk);
        lit_reset(0);
        lit_reset(1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // T1: abort mid-EVAL of word 2, then restart from word 0.
        tick(1'b1, 1'b0, '0, '0);
        for (int j = 1; j <= 7; j++) tick(1'b0, 1'b0, '0, '0);
        chk("t1_pre_eval", 0, W'(pre_o[0]), W'(0));
        chk("t1_idx2",     0, W'(idx_o[0]), W'(2));
        chk("t1_busy",     0, W'(busy_o[0]), W'(1));
        do_reset();

        // T2/T4/T5: nominal block, backpressure in HOLD, slow-phase instance timing.
        tick(1'b1, 1'b0, '0, '0);
        chk("t1_restart_idx",  0, W'(idx_o[0]),  W'(0));
        chk("t1_restart_busy", 0, W'(busy_o[0]), W'(1));
        chk("t5_pre_off0",     1, W'(pre_o[1]),  W'(1));
        for (int j = 1; j <= 20; j++) begin
            s_v = (j >= 13 && j <= 18);
            r_v = (j == 18);
            if ((j % 3 == 0) && j <= 12) begin
                p_v = words[j/3 - 1];
                n_v = ~p_v;
            end else begin
                p_v = '0;
                n_v = '0;
            end
            tick(s_v, r_v, p_v, n_v);
            if (j <= 4) chk("t5_pre_pattern", 1, W'(pre_o[1]), W'(j < 2));
            if (j == 11) chk("t2_valid_early", 0, W'(valid_o[0]), W'(0));
            if (j == 12) begin
                chk("t2_valid", 0, W'(valid_o[0]), W'(1));
                chk("t2_qp",    0, qp_o[0], nom_q);
                chk("t2_qn",    0, qn_o[0], ~nom_q);
                chk("t2_err",   0, W'(err_o[0]), W'(0));
            end
            if (j >= 13 && j <= 17) begin
                chk("t4_valid_hold", 0, W'(valid_o[0]), W'(1));
                chk("t4_q_hold",     0, qp_o[0], nom_q);
                chk("t4_busy_hold",  0, W'(busy_o[0]), W'(1));
            end
            if (j == 18) begin
                chk("t4_valid_drop", 0, W'(valid_o[0]), W'(0));
                chk("t4_idle",       0, W'(busy_o[0]),  W'(0));
                chk("t4_q_retained", 0, qp_o[0], nom_q);
            end
            if (j == 19) begin
                chk("t4_start_ignored", 0, W'(busy_o[0]),  W'(0));
                chk("t5_valid_early",   1, W'(valid_o[1]), W'(0));
            end
            if (j == 20) chk("t5_valid_20", 1, W'(valid_o[1]), W'(1));
        end
        drain();

        // T3: rail error on word 1 bit 5, sticky through HOLD, cleared by start.
        tick(1'b1, 1'b0, '0, '0);
        for (int j = 1; j <= 13; j++) begin
            if ((j % 3 == 0) && j <= 12) begin
                p_v = words[j/3 - 1] ^ 32'h5A5A5A5A;
                n_v = ~p_v;
                if (j == 6) begin
                    p_v = p_v | 32'h20;
                    n_v = n_v | 32'h20;
                end
            end else begin
                p_v = '0;
                n_v = '0;
            end
            tick(1'b0, (j == 13), p_v, n_v);
            if (j == 5)  chk("t3_err_before", 0, W'(err_o[0]), W'(0));
            if (j == 6)  chk("t3_err_set",    0, W'(err_o[0]), W'(1));
            if (j == 12) chk("t3_err_hold",   0, W'(err_o[0]), W'(1));
            if (j == 13) chk("t3_err_idle",   0, W'(err_o[0]), W'(1));
        end
        tick(1'b1, 1'b0, '0, '0);
        chk("t3_err_clear", 0, W'(err_o[0]), W'(0));

        // T6: a 1 on d_p_in[0] in the last PRE cycle of word 1.
        for (int j = 1; j <= 12; j++) begin
            if (j % 3 == 0) begin
                p_v = words[j/3 - 1];
                n_v = ~p_v;
            end else if (j == 4) begin
                p_v = 32'h1;
                n_v = '0;
            end else begin
                p_v = '0;
                n_v = '0;
            end
            tick(1'b0, 1'b0, p_v, n_v);
            if (j == 3)  chk("t6_err_before", 0, W'(err_o[0]), W'(0));
            if (j == 4)  chk("t6_pre_check",  0, W'(err_o[0]), W'(PCHK));
            if (j == 12) chk("t6_err_end",    0, W'(err_o[0]), W'(PCHK));
        end
        drain();

        // Randomized traffic with occasional asynchronous resets.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rsel = $urandom_range(0, 15);
                p_v  = $urandom;
                if (rsel == 0) begin
                    n_v = $urandom;
                end else if (rsel < 6) begin
                    p_v = '0;
                    n_v = '0;
                end else if (rsel == 6) begin
                    n_v = (~p_v) ^ (32'h1 << $urandom_range(0, 31));
                end else begin
                    n_v = ~p_v;
                end
                s_v = ($urandom_range(0, 3) == 0);
                r_v = ($urandom_range(0, 1) == 0);
                tick(s_v, r_v, p_v, n_v);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
